// File: rtl/dma_rr_scheduler.sv
// dma_rr_scheduler: round-robin arbiter in front of a shared single-port memory.
// The winning channel's block is copied one byte at a time as a READ cycle
// followed by a WRITE cycle. Every output comes straight from a flop.
module dma_rr_scheduler #(
    parameter int NUM_CH = 4,
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int LW     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*AW-1:0] ch_src,
    input  logic [NUM_CH*AW-1:0] ch_dst,
    input  logic [NUM_CH*LW-1:0] ch_len,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_data_in,
    output logic                 mem_we_n,
    output logic                 mem_ce_n,
    input  logic [DW-1:0]        mem_data_out
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cur_src_q, cur_src_d;
    logic [AW-1:0]       cur_dst_q, cur_dst_d;
    logic [LW-1:0]       remaining_q, remaining_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          grant_id_q, grant_id_d;
    logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
    logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
    logic                busy_q, busy_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_data_in_q, mem_data_in_d;
    logic                mem_we_n_q, mem_we_n_d;
    logic                mem_ce_n_q, mem_ce_n_d;

    logic                req_any;
    logic [CW-1:0]       win_c;
    logic [CW-1:0]       idx_c;
    logic [AW-1:0]       win_src, win_dst;
    logic [LW-1:0]       win_len;

    // Round-robin pick: first requester after the last served channel, with wrap.
    always_comb begin
        req_any = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx_c = CW'((int'(rr_ptr_q) + off) % NUM_CH);
            if (!req_any && ch_req[idx_c]) begin
                req_any = 1'b1;
                win_c   = idx_c;
            end
        end
        win_src = AW'(ch_src >> (int'(win_c) * AW));
        win_dst = AW'(ch_dst >> (int'(win_c) * AW));
        win_len = LW'(ch_len >> (int'(win_c) * LW));
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so the memory port shows each state's values during that state.
    // mem_data_in_q doubles as the byte buffer between READ and WRITE.
    always_comb begin
        state_d       = state_q;
        cur_src_d     = cur_src_q;
        cur_dst_d     = cur_dst_q;
        remaining_d   = remaining_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        ch_ack_d      = '0;
        ch_done_d     = '0;
        busy_d        = busy_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_n_d    = 1'b1;
        mem_ce_n_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d     = READ;
                    cur_src_d   = win_src;
                    cur_dst_d   = win_dst;
                    remaining_d = win_len;
                    grant_id_d  = 3'(win_c);
                    ch_ack_d    = {{(NUM_CH-1){1'b0}}, 1'b1} << win_c;
                    busy_d      = 1'b1;
                    mem_addr_d  = win_src;
                    mem_ce_n_d  = 1'b0;
                end
            end
            READ: begin
                state_d       = WRITE;
                mem_data_in_d = mem_data_out;
                mem_addr_d    = cur_dst_q;
                mem_ce_n_d    = 1'b0;
                mem_we_n_d    = 1'b0;
            end
            WRITE: begin
                if (remaining_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d     = READ;
                    cur_src_d   = cur_src_q + AW'(1);
                    cur_dst_d   = cur_dst_q + AW'(1);
                    remaining_d = remaining_q - LW'(1);
                    mem_addr_d  = cur_src_q + AW'(1);
                    mem_ce_n_d  = 1'b0;
                end
            end
            DONE: begin
                state_d   = IDLE;
                ch_done_d = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_id_q;
                rr_ptr_d  = grant_id_q;
                busy_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_src_q     <= '0;
            cur_dst_q     <= '0;
            remaining_q   <= '0;
            rr_ptr_q      <= 3'(NUM_CH - 1);
            grant_id_q    <= '0;
            ch_ack_q      <= '0;
            ch_done_q     <= '0;
            busy_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_we_n_q    <= 1'b1;
            mem_ce_n_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cur_src_q     <= cur_src_d;
            cur_dst_q     <= cur_dst_d;
            remaining_q   <= remaining_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            ch_ack_q      <= ch_ack_d;
            ch_done_q     <= ch_done_d;
            busy_q        <= busy_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_n_q    <= mem_we_n_d;
            mem_ce_n_q    <= mem_ce_n_d;
        end
    end

    assign ch_ack      = ch_ack_q;
    assign ch_done     = ch_done_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_we_n    = mem_we_n_q;
    assign mem_ce_n    = mem_ce_n_q;

endmodule
